// File: rtl/my_if_stream_source.sv
// Upstream byte source for the my_if data path: valid/ready producer port into a
// first-word-fall-through FIFO, with occupancy and producer-stall reporting.
module my_if_stream_source #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     level,
    output logic [7:0]                 stall_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [LW-1:0]    level_q;
    logic [7:0]       stall_q;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic stall;

    // Status comes only from the registered level, so ready/valid never depend
    // combinationally on the opposite handshake.
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign push  = in_valid && !full && !flush;
    assign pop   = !empty && out_ready && !flush;
    assign stall = in_valid && full;

    assign in_ready    = !full;
    assign out_valid   = !empty;
    assign out_data    = mem[rp];
    assign level       = level_q;
    assign stall_count = stall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp      <= '0;
            rp      <= '0;
            level_q <= '0;
            stall_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wp] <= in_data;
            end

            if (flush) begin
                wp      <= '0;
                rp      <= '0;
                level_q <= '0;
            end else begin
                if (push) begin
                    wp <= wp + AW'(1);
                end
                if (pop) begin
                    rp <= rp + AW'(1);
                end
                case ({push, pop})
                    2'b10:   level_q <= level_q + LW'(1);
                    2'b01:   level_q <= level_q - LW'(1);
                    default: level_q <= level_q;
                endcase
            end

            // Stalls keep counting through a flush and saturate at 255.
            if (stall && (stall_q != 8'hFF)) begin
                stall_q <= stall_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_my_if_stream_source.sv
// Bench for my_if_stream_source: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_my_if_stream_source;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             flush;
    logic [LW-1:0]    level;
    logic [7:0]       stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] q[$];
    int               m_stall = 0;

    my_if_stream_source #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .flush       (flush),
        .level       (level),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bounded queue plus a saturating stall counter.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_stall = 0;
        end else begin
            bit rdy, do_push, do_pop;
            rdy     = (q.size() < DEPTH);
            do_push = in_valid && rdy && !flush;
            do_pop  = (q.size() > 0) && out_ready && !flush;
            if (in_valid && !rdy && m_stall < 255) m_stall++;
            if (flush) begin
                q.delete();
            end else begin
                if (do_pop) void'(q.pop_front());
                if (do_push) q.push_back(in_data);
            end
        end
    end

    always @(negedge clk) begin
        check("model_out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("model_in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        check("model_level", 32'(level), 32'(q.size()));
        check("model_stall_count", 32'(stall_count), 32'(m_stall));
        if (q.size() != 0) check("model_out_data", 32'(out_data), 32'(q[0]));
    end

    // Apply inputs, take one clock edge, return 1ns after it.
    task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_level"}, 32'(level), 32'd0);
        check({tag, "_stall"}, 32'(stall_count), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #3;
        check_reset_values("rst_init");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Fill, stall, drain
        cyc(1, 8'h11, 0, 0);
        cyc(1, 8'h22, 0, 0);
        cyc(1, 8'h33, 0, 0);
        cyc(1, 8'h44, 0, 0);
        check("fill_level", 32'(level), 32'd4);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) cyc(1, 8'h55, 0, 0);
        check("stall_count3", 32'(stall_count), 32'd3);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("drain_head0", 32'(out_data), 32'h11);
        cyc(0, 8'h00, 1, 0);
        check("drain_head1", 32'(out_data), 32'h22);
        cyc(0, 8'h00, 1, 0);
        check("drain_head2", 32'(out_data), 32'h33);
        cyc(0, 8'h00, 1, 0);
        check("drain_head3", 32'(out_data), 32'h44);
        cyc(0, 8'h00, 1, 0);
        check("drain_empty", 32'(out_valid), 32'd0);

        // Streaming with pointer wrap: each byte visible one cycle after its push
        for (int i = 0; i < 10; i++) begin
            cyc(1, 8'(i), 1, 0);
            check("stream_data", 32'(out_data), 32'(i));
            check("stream_level", 32'(level), 32'd1);
        end
        cyc(0, 8'h00, 1, 0);
        check("stream_drained", 32'(out_valid), 32'd0);

        // Simultaneous push and pop at level 2
        cyc(1, 8'hA1, 0, 0);
        cyc(1, 8'hA2, 0, 0);
        check("pp_level_before", 32'(level), 32'd2);
        cyc(1, 8'hA3, 1, 0);
        check("pp_level", 32'(level), 32'd2);
        check("pp_head", 32'(out_data), 32'hA2);

        // Flush overrides push and pop
        cyc(1, 8'hA4, 0, 0);
        check("fl_level_before", 32'(level), 32'd3);
        cyc(1, 8'hAA, 1, 1);
        check("fl_level", 32'(level), 32'd0);
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_stall", 32'(stall_count), 32'd3);
        cyc(0, 8'h00, 1, 0);
        check("fl_still_empty", 32'(out_valid), 32'd0);

        // Reset mid-operation at level 2, stall_count 5
        for (int i = 0; i < 4; i++) cyc(1, 8'(8'hB0 + i), 0, 0);
        cyc(1, 8'hEE, 0, 0);
        cyc(1, 8'hEE, 0, 0);
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 0);
        check("mid_level", 32'(level), 32'd2);
        check("mid_stall", 32'(stall_count), 32'd5);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1 reset_n = 1'b0;
        #1 check_reset_values("rst_mid");
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1, 8'h7E, 0, 0);
        check("post_rst_data", 32'(out_data), 32'h7E);
        check("post_rst_valid", 32'(out_valid), 32'd1);

        // Saturation of the stall counter
        for (int i = 0; i < 300; i++) cyc(1, 8'hC3, 0, 0);
        check("stall_sat", 32'(stall_count), 32'd255);
        cyc(0, 8'h00, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 31) == 0));
        end
        cyc(0, 8'h00, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/my_if_stream_source.md
# my_if_stream_source

Upstream stage of the 8-bit `my_if` data path. It accepts bytes from a producer on a valid/ready handshake and buffers them in a small first-word-fall-through FIFO. It presents them on the AccessIn side of `my_if` (drives `data`/`valid`, samples `ready`) to the registering stage that consumes `vif.data`. It also reports occupancy and counts producer stalls so back-pressure from the downstream stage is observable.

## Interface
- `WIDTH`, default 8: data width; must match `my_if.data`.
- `DEPTH`, default 4: FIFO entries. Must be a power of two, ≥ 2.
- `clk` input, 1: sole clock; all state updates on the rising edge.
- `reset_n` input, 1: asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `in_valid` input, 1: producer presents `in_data`.
- `in_data` input, WIDTH: producer byte.
- `in_ready` output, 1: FIFO can accept; equals `!full`.
- `out_valid` output, 1: drives `my_if.valid`; equals `!empty`.
- `out_data` output, WIDTH: drives `my_if.data`; head-of-FIFO entry.
- `out_ready` input, 1: sampled from `my_if.ready`.
- `flush` input, 1: synchronous discard of all buffered data.
- `level` output, $clog2(DEPTH)+1: current entry count, 0..DEPTH.
- `stall_count` output, 8: saturating count of cycles with `in_valid && !in_ready`.

## Operation
- Storage: DEPTH×WIDTH array, write pointer `wp` and read pointer `rp` of $clog2(DEPTH) bits, plus `level` register. Pointers wrap modulo DEPTH.
- Push = `in_valid && in_ready && !flush`. Writes `in_data` at `wp`, then `wp` increments.
- Pop = `out_valid && out_ready && !flush`. `rp` increments.
- `level` update:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged.
  - Neither: unchanged.
- full = (`level == DEPTH`); empty = (`level == 0`). Both are derived from the registered `level`, never from pointer equality.
- No bypass: when empty, a push is not visible on `out_data` until the following cycle. When full, `in_ready` = 0, so a same-cycle pop does not admit a new byte.
- `out_data` = `mem[rp]` (combinational read of registered state). Its value is don't-care when `out_valid` = 0, but it must not be X after reset; clear the array on reset.
- `flush`:
  - Next edge sets `wp` = `rp` = 0 and `level` = 0.
  - Overrides any push/pop in the same cycle; the offered byte is dropped and the pop does not count as a transfer.
  - Does not clear `stall_count`.
- `stall_count` increments by 1 on each edge where `in_valid && !in_ready`, including during `flush`. It holds at 255.
- Data order is strictly FIFO, with no reordering or duplication.

## Timing
- Reset (`reset_n` low, asynchronous):
  - `level`=0, `wp`=`rp`=0, `stall_count`=0, `out_valid`=0, `in_ready`=1, `out_data`=0.
  - Applies immediately, without waiting for an edge.
  - Release is synchronous to `clk`; the first push can occur on the first rising edge with `reset_n` high.
- Latency: byte pushed at edge N is on `out_data` with `out_valid`=1 after edge N (visible in cycle N+1), when the FIFO was empty.
- Throughput: one push and one pop per cycle sustained when 0 < `level` < DEPTH.
- `in_ready` and `out_valid` change only after clock edges or asynchronous reset. There is no combinational path from `out_ready` to `in_ready`, or from `in_valid` to `out_valid`.
- Reset mid-operation discards all contents; `stall_count` returns to 0.
- Pointer wrap: after DEPTH pushes, `wp` returns to 0 with no data corruption.

## Test plan
- Reset values: assert `reset_n`=0 between edges → `out_valid`=0, `in_ready`=1, `level`=0, `stall_count`=0 immediately.
- Fill and drain (DEPTH=4):
  - Push 8'h11, 22, 33, 44 with `out_ready`=0 → `level`=4, `in_ready`=0.
  - Hold `in_valid`=1 with 8'h55 for 3 cycles → `stall_count`=3, byte 8'h55 not stored.
  - Raise `out_ready` → `out_data` 11, 22, 33, 44 on consecutive cycles, then `out_valid`=0.
- Streaming with wrap:
  - Push 10 bytes 8'h00..8'h09 with `out_ready`=1 every cycle → outputs appear one cycle after their push, in order.
  - `level` holds 1 during steady state; pointers wrap twice without error.
- Simultaneous push/pop at `level`=2 → `level` stays 2 and the head byte advances.
- Flush with push:
  - At `level`=3, assert `flush` with `in_valid`=1 (8'hAA) and `out_ready`=1 → next cycle `level`=0, `out_valid`=0.
  - 8'hAA is not stored; `stall_count` is unchanged.
- Reset mid-operation: at `level`=2 with `stall_count`=5, pulse `reset_n` low → all outputs return to reset values. Next push of 8'h7E appears on `out_data` one cycle later.
